// File: rtl/spi_clk_arbiter.sv
// spi_clk_arbiter: round-robin sequencer sharing one SPI clock divider among NUM_REQ requesters.
// Optional SPI_ARB_CFG_CACHE_EN skips the divider reload when the selected divisor is unchanged.
`default_nettype none

module spi_clk_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_div,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_err,
  output logic [8:0]           o_div_config,
  output logic                 o_div_start_n,
  input  logic                 i_div_idle
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CFG      = 3'd1;
  localparam logic [2:0] S_CFG_WAIT = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_RUN_WAIT = 3'd4;
  localparam logic [2:0] S_BUSY     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]         state;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last;
  logic [NUM_REQ-1:0] r_onehot;
  logic [7:0]         r_div;
  logic [7:0]         r_cnt;
  logic               r_err;

  logic [NUM_REQ-1:0] w_above_last;
  logic [NUM_REQ-1:0] w_req_above;
  logic [NUM_REQ-1:0] w_pick_from;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic [3:0]         w_oh4;
  logic [31:0]        w_div4;
  logic [IW-1:0]      w_sel_idx;
  logic [7:0]         w_sel_div;
  logic               w_go;
  logic               w_timeout;
  logic               w_cache_hit;

  // Requesters strictly above r_last get first pick; otherwise wrap to the lowest index.
  assign w_above_last = NUM_REQ'(4'b1111 << ({1'b0, 2'(r_last)} + 3'd1));
  assign w_req_above  = i_req & w_above_last;
  assign w_pick_from  = (|w_req_above) ? w_req_above : i_req;
  assign w_sel_onehot = w_pick_from & (~w_pick_from + NUM_REQ'(1));

  // Index and divisor muxes are written for the 4-requester maximum and zero-padded.
  assign w_oh4     = 4'(w_sel_onehot);
  assign w_div4    = 32'(i_div);
  assign w_sel_idx = IW'({w_oh4[2] | w_oh4[3], w_oh4[1] | w_oh4[3]});
  assign w_sel_div = ({8{w_oh4[0]}} & w_div4[7:0])   |
                     ({8{w_oh4[1]}} & w_div4[15:8])  |
                     ({8{w_oh4[2]}} & w_div4[23:16]) |
                     ({8{w_oh4[3]}} & w_div4[31:24]);

  assign w_go      = (|i_req) && i_div_idle;
  assign w_timeout = (((state == S_CFG_WAIT) && !i_div_idle) ||
                      ((state == S_RUN_WAIT) &&  i_div_idle)) && (r_cnt == TO_LIMIT);

`ifdef SPI_ARB_CFG_CACHE_EN
  logic [7:0] r_cfg_last;
  logic       r_cfg_valid;

  assign w_cache_hit = r_cfg_valid && (w_sel_div == r_cfg_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_last  <= 8'h00;
      r_cfg_valid <= 1'b0;
    end else if (state == S_CFG) begin
      r_cfg_last  <= r_div;
      r_cfg_valid <= 1'b1;
    end else if (w_timeout) begin
      r_cfg_valid <= 1'b0;
    end
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      r_idx    <= '0;
      r_last   <= IW'(NUM_REQ - 1);
      r_onehot <= '0;
      r_div    <= 8'h00;
      r_cnt    <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_go) begin
            r_idx    <= w_sel_idx;
            r_onehot <= w_sel_onehot;
            r_div    <= w_sel_div;
            state    <= w_cache_hit ? S_START : S_CFG;
          end
        end
        S_CFG: begin
          r_cnt <= 8'h00;
          state <= S_CFG_WAIT;
        end
        S_CFG_WAIT: begin
          if (i_div_idle) begin
            state <= S_START;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_START: begin
          r_cnt <= 8'h00;
          state <= S_RUN_WAIT;
        end
        S_RUN_WAIT: begin
          if (!i_div_idle) begin
            state <= S_BUSY;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // Burst length scales with the divisor, so no timeout while busy.
        S_BUSY: begin
          if (i_div_idle) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          r_last <= r_idx;
          r_err  <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = (state != S_IDLE) ? r_onehot : '0;
  assign o_done        = (state == S_DONE) ? r_onehot : '0;
  assign o_err         = (state == S_DONE) && r_err;
  assign o_div_config  = (state == S_CFG) ? {r_div, 1'b1} : 9'h000;
  assign o_div_start_n = (state != S_START);

endmodule

`default_nettype wire

// File: tb/tb_spi_clk_arbiter.sv
// tb_spi_clk_arbiter: directed and randomized checks of spi_clk_arbiter against a transaction-level model.
`default_nettype none

module tb_spi_clk_arbiter;

  localparam int N  = 2;
  localparam int TO = 15;
`ifdef SPI_ARB_CFG_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] div = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic [8:0]     cfg;
  logic           start_n;
  logic           idle = 1'b1;

  spi_clk_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_div(div),
    .o_grant(grant), .o_done(done), .o_err(err),
    .o_div_config(cfg), .o_div_start_n(start_n), .i_div_idle(idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: phase of the current grant, owner, wait time.
  localparam int P_IDLE = 0, P_CFG = 1, P_CFGW = 2, P_START = 3, P_RUNW = 4, P_BUSY = 5, P_DONE = 6;
  int         m_ph = P_IDLE;
  int         m_own = 0;
  int         m_last = N - 1;
  int         m_wait = 0;
  bit         m_err = 1'b0;
  logic [7:0] m_div = 8'h00;
  bit         m_cv = 1'b0;
  logic [7:0] m_cd = 8'h00;

  always @(posedge clk or posedge rst) begin
    int  cand;
    bit  found;
    if (rst) begin
      m_ph = P_IDLE; m_own = 0; m_last = N - 1; m_wait = 0; m_err = 1'b0;
      m_div = 8'h00; m_cv = 1'b0; m_cd = 8'h00;
    end else begin
      case (m_ph)
        P_IDLE: if (req != '0 && idle) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            cand = (m_last + k) % N;
            if (!found && req[cand]) begin
              found = 1'b1;
              m_own = cand;
            end
          end
          m_div = div[8*m_own +: 8];
          m_ph  = (CACHE && m_cv && m_div == m_cd) ? P_START : P_CFG;
        end
        P_CFG: begin
          m_cv = 1'b1; m_cd = m_div; m_wait = 0; m_ph = P_CFGW;
        end
        P_CFGW: begin
          if (idle) m_ph = P_START;
          else if (m_wait >= TO) begin m_ph = P_DONE; m_err = 1'b1; m_cv = 1'b0; end
          else m_wait++;
        end
        P_START: begin
          m_wait = 0; m_ph = P_RUNW;
        end
        P_RUNW: begin
          if (!idle) m_ph = P_BUSY;
          else if (m_wait >= TO) begin m_ph = P_DONE; m_err = 1'b1; m_cv = 1'b0; end
          else m_wait++;
        end
        P_BUSY: if (idle) m_ph = P_DONE;
        default: begin
          m_last = m_own; m_err = 1'b0; m_ph = P_IDLE;
        end
      endcase
    end
  end

  // Divider model: idle low for one cycle after a config strobe, run_len cycles after start.
  int dv_cnt = 0;
  int dv_mode = 0;   // 0 normal, 1 ignores start, 2 config never finishes
  int run_len = 3;
  bit glitch_en = 1'b0;

  int n_cfg = 0, n_start = 0, n_done = 0, viol = 0;
  int cfg_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [8:0]   cfg_val = '0;
  logic [N-1:0] done_val = '0;
  logic         done_err = 1'b0;
  logic [N-1:0] prev_grant = '0, prev_done = '0;

  task automatic check_outputs();
    logic [N-1:0] e_grant, e_done;
    logic         e_err, e_sn;
    logic [8:0]   e_cfg;
    e_grant = '0;
    e_done  = '0;
    if (m_ph != P_IDLE) e_grant[m_own] = 1'b1;
    if (m_ph == P_DONE) e_done[m_own] = 1'b1;
    e_err = (m_ph == P_DONE) && m_err;
    e_cfg = (m_ph == P_CFG) ? {m_div, 1'b1} : 9'h000;
    e_sn  = (m_ph != P_START);
    tests++;
    if (grant !== e_grant || done !== e_done || err !== e_err || cfg !== e_cfg || start_n !== e_sn) begin
      fails++;
      $display("FAIL model cyc=%0d grant=%b/%b done=%b/%b err=%b/%b cfg=%h/%h start_n=%b/%b (got/expected)",
               cyc, grant, e_grant, done, e_done, err, e_err, cfg, e_cfg, start_n, e_sn);
    end
    if (done != '0) begin
      tests++;
      if (done !== grant) begin
        fails++;
        $display("FAIL done_vs_grant: done=%b, grant=%b", done, grant);
      end
    end
  endtask

  task automatic divider_update();
    bit g;
    g = glitch_en && (grant == '0) && ($urandom_range(0, 3) == 0);
    idle = (dv_cnt == 0) && !g;
    if (dv_cnt > 0) dv_cnt--;
    if (cfg[0]) dv_cnt = (dv_mode == 2) ? 30 : 1;
    if (!start_n && dv_mode != 1) dv_cnt = run_len;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (cfg[0]) begin n_cfg++; cfg_cyc = cyc; cfg_val = cfg; end
    if (!start_n) begin n_start++; start_cyc = cyc; end
    if (done != '0) begin n_done++; done_cyc = cyc; done_val = done; done_err = err; end
    if (prev_grant != '0 && grant != '0 && grant != prev_grant) viol++;
    if (prev_done != '0 && grant != '0) viol++;
    prev_grant = grant;
    prev_done  = done;
    divider_update();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int bound);
    int n0;
    n0 = n_done;
    for (int i = 0; i < bound && n_done == n0; i++) step();
    if (n_done == n0) begin
      tests++; fails++;
      $display("FAIL wait_done: no o_done within %0d cycles", bound);
    end
  endtask

  task automatic wait_start(input int bound);
    int n0;
    n0 = n_start;
    for (int i = 0; i < bound && n_start == n0; i++) step();
    if (n_start == n0) begin
      tests++; fails++;
      $display("FAIL wait_start: no start within %0d cycles", bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv_cnt = 0;
    idle = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    do_reset();
    step();
    chk("reset_grant", 32'(grant), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_cfg", 32'(cfg), 0);
    chk("reset_start_n", 32'(start_n), 1);

    // Single transaction, divisor 8
    div[7:0] = 8'd8; req = 2'b01; run_len = 5;
    wait_done(60);
    chk("t1_cfg_val", 32'(cfg_val), 32'h011);
    chk("t1_start_gap", 32'(start_cyc - cfg_cyc), 3);
    chk("t1_done_gap", 32'(done_cyc - start_cyc), 7);
    chk("t1_done", 32'(done_val), 1);
    chk("t1_err", 32'(done_err), 0);
    req = '0;
    step();

    // Both requesting: strict alternation from reset
    do_reset();
    div = {8'd6, 8'd4}; req = 2'b11; run_len = 3; viol = 0;
    for (int t = 0; t < 4; t++) begin
      wait_done(60);
      chk($sformatf("t2_order%0d", t), 32'(done_val), (t % 2 == 0) ? 1 : 2);
      chk($sformatf("t2_cfg%0d", t), 32'(cfg_val), (t % 2 == 0) ? 32'h009 : 32'h00D);
    end
    chk("t2_idle_gap_violations", 32'(viol), 0);

    // Run-wait timeout on requester 0, then requester 1 gets the next grant
    dv_mode = 1;
    wait_done(80);
    chk("t3_to_owner", 32'(done_val), 1);
    chk("t3_to_err", 32'(done_err), 1);
    chk("t3_to_gap", 32'(done_cyc - (start_cyc + 1)), 16);
    dv_mode = 0;
    wait_done(60);
    chk("t3_next_owner", 32'(done_val), 2);
    chk("t3_next_err", 32'(done_err), 0);
    req = '0;
    step(); step();

    // Asynchronous reset while busy
    div = {8'd6, 8'd8}; req = 2'b01; run_len = 20;
    wait_start(40);
    step(); step();
    n0 = n_done;
    rst = 1'b1;
    dv_cnt = 0;
    #1;
    chk("t4_grant", 32'(grant), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_cfg", 32'(cfg), 0);
    chk("t4_start_n", 32'(start_n), 1);
    step(); step();
    chk("t4_no_done", 32'(n_done - n0), 0);
    rst = 1'b0;
    req = 2'b11; run_len = 3;
    wait_done(60);
    chk("t4_first_owner", 32'(done_val), 1);
    req = '0;
    step(); step();

    // Divisor change and request drop while busy are ignored
    div[15:8] = 8'h33; req = 2'b10; run_len = 10;
    wait_start(40);
    step(); step();
    div[15:8] = 8'h77; req = '0;
    wait_done(40);
    chk("t5_done", 32'(done_val), 2);
    chk("t5_cfg_val", 32'(cfg_val), 32'h067);
    step(); step();

    // Repeated divisor: config strobe skipped only when the cache is built in
    div[7:0] = 8'd10; req = 2'b01; run_len = 3;
    n0 = n_cfg;
    wait_done(60);
    wait_done(60);
    chk("t6_pair_strobes", 32'(n_cfg - n0), CACHE ? 1 : 2);
    dv_mode = 1;
    wait_done(80);
    chk("t6_timeout_err", 32'(done_err), 1);
    dv_mode = 0;
    n0 = n_cfg;
    wait_done(60);
    chk("t6_refill_strobes", 32'(n_cfg - n0), 1);
    chk("t6_refill_cfg", 32'(cfg_val), 32'h015);
    req = '0;
    step(); step();

    // Randomized traffic against the model
    glitch_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      run_len = $urandom_range(1, 8);
      if (grant == '0) begin
        case ($urandom_range(0, 9))
          0: dv_mode = 1;
          1: dv_mode = 2;
          default: dv_mode = 0;
        endcase
      end
      for (int k = 0; k < N; k++) begin
        if (done[k]) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          div[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        end else if (grant[k] && $urandom_range(0, 29) == 0) req[k] = 1'b0;
        if ($urandom_range(0, 9) == 0) div[8*k +: 8] = 8'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        dv_cnt = 0;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
